clk_div_array: RTL

CLK_DIV_ARRAY -- requirements
Module: clk_div_array

---
 rtl/clk_div_array.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/clk_div_array.sv
// Array of independent programmable clock dividers with shadowed configuration,
// phase-aligned restart and optional rising-edge strobes (CLK_DIV_ARRAY_EDGE_STROBE_EN).
module clk_div_array #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 28,
    parameter int DEF_HIGH = 10,
    parameter int DEF_LOW  = 10
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_CH-1:0]       en_i,
    input  logic                    sync_start_i,
    input  logic                    cfg_load_i,
    input  logic [NUM_CH*CNT_W-1:0] high_ticks_i,
    input  logic [NUM_CH*CNT_W-1:0] low_ticks_i,
    input  logic [NUM_CH*CNT_W-1:0] phase_i,
    output logic [NUM_CH-1:0]       clk_o,
    output logic [NUM_CH-1:0]       edge_o,
    output logic [NUM_CH-1:0]       cfg_pending_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PHASE,
        S_HIGH,
        S_LOW
    } state_t;

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HIGH);
    localparam logic [CNT_W-1:0] DEF_L = CNT_W'(DEF_LOW);

    // A programmed tick count of zero behaves as a single cycle.
    function automatic logic [CNT_W-1:0] eff_ticks(input logic [CNT_W-1:0] v);
        return (v == '0) ? ONE : v;
    endfunction

    // sync_start_i wins over a simultaneous cfg_load_i, which is then dropped.
    logic cfg_take;
    assign cfg_take = cfg_load_i & ~sync_start_i;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        state_t           st, st_nxt, start_st;
        logic [CNT_W-1:0] cnt, cnt_nxt, start_cnt;
        logic [CNT_W-1:0] act_h, act_l;
        logic [CNT_W-1:0] sh_h, sh_l, sh_p;
        logic [CNT_W-1:0] in_h, in_l, in_p;
        logic [CNT_W-1:0] src_h, src_l, src_p;
        logic             pend, pend_nxt, apply, clk_q;

        assign in_h = high_ticks_i[k*CNT_W +: CNT_W];
        assign in_l = low_ticks_i[k*CNT_W +: CNT_W];
        assign in_p = phase_i[k*CNT_W +: CNT_W];

        // Values taken on an apply: a same-cycle load bypasses the shadow.
        assign src_h = cfg_take ? in_h : sh_h;
        assign src_l = cfg_take ? in_l : sh_l;
        assign src_p = cfg_take ? in_p : sh_p;

        assign start_st  = (src_p == '0) ? S_HIGH : S_PHASE;
        assign start_cnt = (src_p == '0) ? eff_ticks(src_h) - ONE : src_p - ONE;

        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        always_comb begin
            st_nxt   = st;
            cnt_nxt  = cnt;
            apply    = 1'b0;
            pend_nxt = pend | (cfg_take & (st != S_IDLE));
            if (sync_start_i && en_i[k]) begin
                apply    = 1'b1;
                pend_nxt = 1'b0;
                st_nxt   = start_st;
                cnt_nxt  = start_cnt;
            end else begin
                unique case (st)
                    S_IDLE: begin
                        apply    = 1'b1;
                        pend_nxt = 1'b0;
                        if (en_i[k]) begin
                            st_nxt  = start_st;
                            cnt_nxt = start_cnt;
                        end
                    end
                    S_PHASE: begin
                        if (!en_i[k]) begin
                            st_nxt  = S_IDLE;
                            cnt_nxt = '0;
                        end else if (cnt == '0) begin
                            st_nxt  = S_HIGH;
                            cnt_nxt = eff_ticks(act_h) - ONE;
                        end else begin
                            cnt_nxt = cnt - ONE;
                        end
                    end
                    S_HIGH: begin
                        if (cnt == '0) begin
                            st_nxt  = S_LOW;
                            cnt_nxt = eff_ticks(act_l) - ONE;
                        end else begin
                            cnt_nxt = cnt - ONE;
                        end
                    end
                    S_LOW: begin
                        // Last LOW cycle is the period boundary: safe point to swap values or stop.
                        if (cnt == '0) begin
                            apply    = 1'b1;
                            pend_nxt = 1'b0;
                            if (en_i[k]) begin
                                st_nxt  = S_HIGH;
                                cnt_nxt = eff_ticks(src_h) - ONE;
                            end else begin
                                st_nxt  = S_IDLE;
                                cnt_nxt = '0;
                            end
                        end else begin
                            cnt_nxt = cnt - ONE;
                        end
                    end
                    default: begin
                        st_nxt  = S_IDLE;
                        cnt_nxt = '0;
                    end
                endcase
            end
        end

        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                st    <= S_IDLE;
                cnt   <= '0;
                act_h <= DEF_H;
                act_l <= DEF_L;
                sh_h  <= DEF_H;
                sh_l  <= DEF_L;
                sh_p  <= '0;
                pend  <= 1'b0;
                clk_q <= 1'b0;
            end else begin
                st    <= st_nxt;
                cnt   <= cnt_nxt;
                pend  <= pend_nxt;
                clk_q <= (st_nxt == S_HIGH);
                if (apply) begin
                    act_h <= src_h;
                    act_l <= src_l;
                end
                if (cfg_take) begin
                    sh_h <= in_h;
                    sh_l <= in_l;
                    sh_p <= in_p;
                end
            end
        end

        assign clk_o[k]         = clk_q;
        assign cfg_pending_o[k] = pend;

`ifdef CLK_DIV_ARRAY_EDGE_STROBE_EN
        logic edge_q;
        always_ff @(posedge clk_i) begin
            if (rst_i) edge_q <= 1'b0;
            else       edge_q <= (st_nxt == S_HIGH) && (st != S_HIGH);
        end
        assign edge_o[k] = edge_q;
`else
        assign edge_o[k] = 1'b0;
`endif
    end

endmodule
